// File: rtl/inv_shift_rows_stream_if.sv
// Element stream bundle for the InvShiftRows unit: an input stream into the
// unit and an output stream out of it, each with valid/ready handshaking.
interface inv_shift_rows_stream_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Producer/consumer side: drives input elements, sinks output elements
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Unit side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Streaming AES InvShiftRows: 16 elements in (index order), stored in a
// ping-pong pair of buffers, 16 elements out in inverse-row-rotated order.
// Output element k = input element 4g + ((j - g) mod 4), g = k/4, j = k%4.
module inv_shift_rows_stream #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  inv_shift_rows_stream_if.slave  s,
  output logic [15:0]             block_count,
  output logic                    busy
);

  typedef logic [15:0][DATA_W-1:0] blk_t;

  // Control state
  typedef struct packed {
    logic [1:0]  full;
    logic        wsel;
    logic [3:0]  wcnt;
    logic        rsel;
    logic [3:0]  rcnt;
    logic [15:0] bcnt;
  } ctl_t;

  ctl_t          ctl_q, ctl_d;
  blk_t [1:0]    mem_q, mem_d;

  logic          clr;
  logic          wr_fire;
  logic          rd_fire;
  logic [1:0]    src_col;
  logic [3:0]    src_idx;

  // Soft clear and reset share one path; either drops any handshake in flight
  assign clr     = !rst || run;

  // Inverse rotation: group g reads from column (j - g) mod 4 of the same group
  assign src_col = ctl_q.rcnt[1:0] - ctl_q.rcnt[3:2];
  assign src_idx = {ctl_q.rcnt[3:2], src_col};

  // Stream outputs; in_ready held low during reset
  always_comb begin
    s.in_ready  = rst && !ctl_q.full[ctl_q.wsel];
    s.out_valid = ctl_q.full[ctl_q.rsel];
    s.out_data  = s.out_valid ? mem_q[ctl_q.rsel][src_idx] : '0;
    block_count = ctl_q.bcnt;
    busy        = ctl_q.full[0] || ctl_q.full[1] || (ctl_q.wcnt != 4'd0);
  end

  assign wr_fire = s.in_valid && s.in_ready && !clr;
  assign rd_fire = s.out_valid && s.out_ready && !clr;

  // Next control state: write and read sides update their own buffer flag
  always_comb begin
    ctl_d = ctl_q;
    if (wr_fire) begin
      ctl_d.wcnt = ctl_q.wcnt + 4'd1;
      if (ctl_q.wcnt == 4'd15) begin
        ctl_d.full[ctl_q.wsel] = 1'b1;
        ctl_d.wsel             = !ctl_q.wsel;
      end
    end
    if (rd_fire) begin
      ctl_d.rcnt = ctl_q.rcnt + 4'd1;
      if (ctl_q.rcnt == 4'd15) begin
        ctl_d.full[ctl_q.rsel] = 1'b0;
        ctl_d.rsel             = !ctl_q.rsel;
        ctl_d.bcnt             = ctl_q.bcnt + 16'd1;
      end
    end
    if (clr) ctl_d = '0;
  end

  // Next buffer contents: one element written per accepted input
  always_comb begin
    mem_d = mem_q;
    if (wr_fire) mem_d[ctl_q.wsel][ctl_q.wcnt] = s.in_data;
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) ctl_q <= '0;
    else      ctl_q <= ctl_d;
  end

  // Buffer storage is never cleared; stale data is gated by the full flags
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/inv_shift_rows_stream.md
# inv_shift_rows_stream

Streaming AES InvShiftRows unit for the Versat datapath: the decryption-side counterpart of the combinational ShiftRows unit. It accepts a 16-element state one element per cycle over a valid/ready stream, stores it in a ping-pong buffer, and emits the inverse-row-rotated state one element per cycle. It sits between the AES decrypt key-add/inverse-SubBytes stages and the inverse MixColumns stage. Sustained throughput is 1 element/cycle.

## Interface
- ADDR_W, `ADDR_W, unused; kept for unit-template uniformity
- DATA_W, `DATA_W (32), width of one state element; elements are passed through unmodified
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- run  in  1  synchronous soft clear; same effect as reset, one-cycle pulse
- in_data  in  DATA_W  input element
- in_valid  in  1  in_data valid
- in_ready  out  1  unit accepts in_data this cycle
- out_data  out  DATA_W  output element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data this cycle
- block_count  out  16  completed output blocks, wraps at 0xFFFF->0
- busy  out  1  any buffer full or a block partially written

## Operation
- State element index k=0..15, group g=k/4, position j=k%4; input order = index order.
- Inverse mapping: output element k = input element 4g + ((j - g) mod 4). Output order for input 0..15: 0,1,2,3,7,4,5,6,10,11,8,9,13,14,15,12.
- Storage: two 16×DATA_W buffers B0/B1, flags full[1:0], write select wsel, write counter wcnt (4b), read select rsel, read counter rcnt (4b).
- Write side: in_ready = !full[wsel]. On in_valid&&in_ready: B[wsel][wcnt] <= in_data, wcnt++. When wcnt==15 accepted: full[wsel]<=1, wsel toggles, wcnt wraps to 0.
- Read side: out_valid = full[rsel]; out_data = B[rsel][src(rcnt)] when out_valid, else 0. On out_valid&&out_ready: rcnt++. When rcnt==15 accepted: full[rsel]<=0, rsel toggles, rcnt wraps to 0, block_count++.
- Write and read never target the same buffer in one cycle (write needs !full, read needs full); simultaneous last-write and last-read in the same cycle update both flags independently.
- busy = full[0] | full[1] | (wcnt != 0).
- rst low or run high: full=0, wsel=rsel=0, wcnt=rcnt=0, block_count=0. Buffer contents not cleared. Partial block in flight is discarded.

## Timing
- Reset values: in_ready=0 while rst low, 1 in the first cycle after rst released; out_valid=0; out_data=0; block_count=0; busy=0.
- Latency: first out_valid in the cycle after the 16th input element is accepted.
- Output stall: while out_valid&&!out_ready, out_data and rcnt hold.
- Backpressure: with both buffers full, in_ready=0; in_ready rises the cycle after the last element of the draining buffer is accepted.
- Sustained: with in_valid and out_ready held high, after the 17-cycle fill latency one element in and one out every cycle, no bubbles at block boundaries.
- run asserted in the same cycle as a handshake: clear wins, handshake is dropped (block_count not incremented).

## Test plan
- Single block: inputs 0..15 back-to-back, out_ready=1 -> outputs 0,1,2,3,7,4,5,6,10,11,8,9,13,14,15,12; first out_valid 1 cycle after input 15; block_count=1; busy=0 afterwards.
- Round trip: feed the forward ShiftRows output 0,1,2,3,5,6,7,4,10,11,8,9,15,12,13,14 -> outputs 0..15 in order.
- Streaming: 4 blocks (values 16b+k) with valid/ready held high -> 64 consecutive out_valid cycles, correct per-block ordering, block_count=4.
- Backpressure: out_ready=0, push 40 elements -> in_ready drops after the 32nd; raise out_ready -> in_ready returns the cycle after the 16th output; no loss or duplication.
- Random stalls: random in_valid/out_ready over 100 blocks -> output matches model; out_data stable during every stall.
- Mid-block clear: accept 7 elements, pulse run (then separately rst=0) -> out_valid=0, busy=0, block_count=0; next full block outputs the correct mapping with no stale data.
